// File: rtl/sar_pkg.sv
// sar_pkg: shared FSM state, comparator flag bundle and one-hot check for sar_search
package sar_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, FINISH} sar_state_t;
    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_flags_t;
    function automatic logic is_one_hot(cmp_flags_t f);
        return f == 3'b100 || f == 3'b010 || f == 3'b001;
    endfunction
endpackage

// File: rtl/sar_search.sv
// sar_search: successive-approximation controller driving a comparator b operand
// Ports: clk, rst (async, active-high), start; a_gt_b/a_eq_b/a_lt_b comparator flags in;
// guess trial value out; busy, done pulse; result, err, steps held until next accepted start.
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CMP_LAT = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         a_gt_b,
    input  logic                         a_eq_b,
    input  logic                         a_lt_b,
    output logic [WIDTH-1:0]             guess,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH-1:0]             result,
    output logic                         err,
    output logic [$clog2(WIDTH+1)-1:0]   steps
);
    localparam int SW = $clog2(WIDTH + 1);
    localparam int CW = CMP_LAT > 0 ? $clog2(CMP_LAT + 1) : 1;
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
    localparam sar_state_t RUN = CMP_LAT > 0 ? SETTLE : DECIDE;
    sar_state_t state;
    cmp_flags_t flags;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] kept;
    logic [CW-1:0] cnt;
    logic ok;
    // mask is the one-hot form of the bit index under trial; mask[0] marks the last compare
    assign flags = {a_gt_b, a_eq_b, a_lt_b};
    assign ok = is_one_hot(flags);
    assign kept = flags.gt ? guess : guess & ~mask;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            guess  <= '0;
            mask   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
            steps  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        guess  <= MSB;
                        mask   <= MSB;
                        busy   <= 1'b1;
                        result <= '0;
                        err    <= 1'b0;
                        steps  <= '0;
                        cnt    <= '0;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(CMP_LAT - 1)) state <= DECIDE;
                end
                DECIDE: begin
                    steps <= steps + SW'(1);
                    if (!ok || flags.eq || mask[0]) begin
                        state  <= FINISH;
                        busy   <= 1'b0;
                        guess  <= '0;
                        result <= !ok ? '0 : flags.eq ? guess : kept;
                        err    <= !ok;
                    end else begin
                        state <= RUN;
                        guess <= kept | (mask >> 1);
                        mask  <= mask >> 1;
                        cnt   <= '0;
                    end
                end
                FINISH: begin
                    // done is registered, so it rises on the edge leaving FINISH
                    done  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
